// File: rtl/pipeline_front_regs.sv
// Purpose : PC register, IF/ID and ID/EX pipeline registers, plus stall/flush performance counters.
// Latency : if_instr at cycle N appears in id_instr at N+1; its decode appears in ex_* at N+2.
// Backpres: pc_write_enable / if_id_write_enable low hold PC / IF/ID; ID/EX takes a bubble instead.
//
// Ports
//   clk, rst                 : single clock, synchronous active-high reset (overrides everything)
//   pc_write_enable          : 0 holds the PC (stall)
//   if_id_write_enable       : 0 holds IF/ID and forces a bubble into ID/EX (load-use)
//   flush_ex                 : 1 forces a bubble into ID/EX
//   pc_redirect, redirect_target : resolved branch/jump; PC jumps, IF/ID is squashed
//   if_instr                 : instruction fetched at pc
//   id_*                     : decode-stage fields for the instruction currently in IF/ID
//   pc, id_*, ex_*           : registered stage contents
//   stall_cycles, flush_cycles : saturating performance counters
module pipeline_front_regs #(
    parameter int unsigned     XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0]     NOP_INSTR = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            rst,

    // hazard / redirect controls
    input  logic            pc_write_enable,
    input  logic            if_id_write_enable,
    input  logic            flush_ex,
    input  logic            pc_redirect,
    input  logic [XLEN-1:0] redirect_target,

    // fetch
    input  logic [31:0]     if_instr,

    // decode fields
    input  logic [4:0]      id_rs1,
    input  logic [4:0]      id_rs2,
    input  logic [4:0]      id_rd,
    input  logic [XLEN-1:0] id_rs1_data,
    input  logic [XLEN-1:0] id_rs2_data,
    input  logic [XLEN-1:0] id_imm,
    input  logic [3:0]      id_alu_ctrl,
    input  logic            id_regwrite,
    input  logic            id_memread,
    input  logic            id_memwrite,
    input  logic            id_branch,
    input  logic            id_jump,

    // fetch address
    output logic [XLEN-1:0] pc,

    // IF/ID contents
    output logic [XLEN-1:0] id_pc,
    output logic [31:0]     id_instr,
    output logic            id_valid,

    // ID/EX contents
    output logic [XLEN-1:0] ex_pc,
    output logic [XLEN-1:0] ex_rs1_data,
    output logic [XLEN-1:0] ex_rs2_data,
    output logic [XLEN-1:0] ex_imm,
    output logic [4:0]      ex_rs1,
    output logic [4:0]      ex_rs2,
    output logic [4:0]      ex_rd,
    output logic [3:0]      ex_alu_ctrl,
    output logic            ex_regwrite,
    output logic            ex_memread,
    output logic            ex_memwrite,
    output logic            ex_branch,
    output logic            ex_jump,
    output logic            ex_valid,

    // performance counters
    output logic [31:0]     stall_cycles,
    output logic [31:0]     flush_cycles
);

    // ------------------------------------------------------------------
    // Stage register layouts
    // ------------------------------------------------------------------
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     instr;
        logic            valid;
    } ifid_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
        logic [XLEN-1:0] imm;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [3:0]      alu_ctrl;
        logic            regwrite;
        logic            memread;
        logic            memwrite;
        logic            branch;
        logic            jump;
        logic            valid;
    } idex_t;

    localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [XLEN-1:0] pc_q,    pc_d;
    ifid_t           ifid_q,  ifid_d;
    idex_t           idex_q,  idex_d;
    logic [31:0]     stall_q, stall_d;
    logic [31:0]     flush_q, flush_d;

    logic            idex_bubble;

    // ------------------------------------------------------------------
    // PC next state: hold beats redirect beats sequential fetch.
    // The +4 is naturally modulo 2^XLEN, so the top word wraps to 0.
    // ------------------------------------------------------------------
    always_comb begin
        pc_d = pc_q;
        if (pc_write_enable) begin
            if (pc_redirect) begin
                pc_d = redirect_target;
            end else begin
                pc_d = pc_q + XLEN'(4);
            end
        end
    end

    // ------------------------------------------------------------------
    // IF/ID next state. A stall holds the register even when a redirect
    // is pending, so the stalled instruction is not lost; the redirect is
    // expected to be re-presented once the stall clears.
    // ------------------------------------------------------------------
    always_comb begin
        ifid_d = ifid_q;
        if (if_id_write_enable) begin
            if (pc_redirect) begin
                ifid_d.pc    = pc_q;
                ifid_d.instr = NOP_INSTR;
                ifid_d.valid = 1'b0;
            end else begin
                ifid_d.pc    = pc_q;
                ifid_d.instr = if_instr;
                ifid_d.valid = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // ID/EX next state. A held IF/ID means the instruction in decode will
    // be re-issued next cycle, so EX must see a bubble now (load-use),
    // independent of flush_ex.
    // ------------------------------------------------------------------
    assign idex_bubble = flush_ex || !if_id_write_enable;

    always_comb begin
        idex_d = '0;
        if (!idex_bubble) begin
            idex_d.pc       = ifid_q.pc;
            idex_d.rs1_data = id_rs1_data;
            idex_d.rs2_data = id_rs2_data;
            idex_d.imm      = id_imm;
            idex_d.rs1      = id_rs1;
            idex_d.rs2      = id_rs2;
            idex_d.rd       = id_rd;
            idex_d.alu_ctrl = id_alu_ctrl;
            idex_d.valid    = ifid_q.valid;
            // A squashed decode slot must never write state downstream.
            idex_d.regwrite = id_regwrite && ifid_q.valid;
            idex_d.memread  = id_memread  && ifid_q.valid;
            idex_d.memwrite = id_memwrite && ifid_q.valid;
            idex_d.branch   = id_branch   && ifid_q.valid;
            idex_d.jump     = id_jump     && ifid_q.valid;
        end
    end

    // ------------------------------------------------------------------
    // Saturating performance counters
    // ------------------------------------------------------------------
    always_comb begin
        stall_d = stall_q;
        if (!pc_write_enable && (stall_q != CNT_MAX)) begin
            stall_d = stall_q + 32'd1;
        end
    end

    always_comb begin
        flush_d = flush_q;
        if (flush_ex && (flush_q != CNT_MAX)) begin
            flush_d = flush_q + 32'd1;
        end
    end

    // ------------------------------------------------------------------
    // Registers. Reset wins over every other input, discarding any
    // stall or redirect that was in flight.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q         <= RESET_PC;
            ifid_q.pc    <= RESET_PC;
            ifid_q.instr <= NOP_INSTR;
            ifid_q.valid <= 1'b0;
            idex_q       <= '0;
            stall_q      <= '0;
            flush_q      <= '0;
        end else begin
            pc_q         <= pc_d;
            ifid_q       <= ifid_d;
            idex_q       <= idex_d;
            stall_q      <= stall_d;
            flush_q      <= flush_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs come straight from registers
    // ------------------------------------------------------------------
    assign pc           = pc_q;

    assign id_pc        = ifid_q.pc;
    assign id_instr     = ifid_q.instr;
    assign id_valid     = ifid_q.valid;

    assign ex_pc        = idex_q.pc;
    assign ex_rs1_data  = idex_q.rs1_data;
    assign ex_rs2_data  = idex_q.rs2_data;
    assign ex_imm       = idex_q.imm;
    assign ex_rs1       = idex_q.rs1;
    assign ex_rs2       = idex_q.rs2;
    assign ex_rd        = idex_q.rd;
    assign ex_alu_ctrl  = idex_q.alu_ctrl;
    assign ex_regwrite  = idex_q.regwrite;
    assign ex_memread   = idex_q.memread;
    assign ex_memwrite  = idex_q.memwrite;
    assign ex_branch    = idex_q.branch;
    assign ex_jump      = idex_q.jump;
    assign ex_valid     = idex_q.valid;

    assign stall_cycles = stall_q;
    assign flush_cycles = flush_q;

endmodule

// File: tb/tb_pipeline_front_regs.sv
module tb_pipeline_front_regs;

    localparam int XLEN = 32;

    logic            clk;
    logic            rst;
    logic            pc_write_enable;
    logic            if_id_write_enable;
    logic            flush_ex;
    logic            pc_redirect;
    logic [XLEN-1:0] redirect_target;
    logic [31:0]     if_instr;
    logic [4:0]      id_rs1, id_rs2, id_rd;
    logic [XLEN-1:0] id_rs1_data, id_rs2_data, id_imm;
    logic [3:0]      id_alu_ctrl;
    logic            id_regwrite, id_memread, id_memwrite, id_branch, id_jump;

    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] id_pc;
    logic [31:0]     id_instr;
    logic            id_valid;
    logic [XLEN-1:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
    logic [4:0]      ex_rs1, ex_rs2, ex_rd;
    logic [3:0]      ex_alu_ctrl;
    logic            ex_regwrite, ex_memread, ex_memwrite, ex_branch, ex_jump, ex_valid;
    logic [31:0]     stall_cycles, flush_cycles;

    int n_assert = 0;
    int n_fail   = 0;

    pipeline_front_regs #(
        .XLEN      (XLEN),
        .RESET_PC  (32'h0000_0000),
        .NOP_INSTR (32'h0000_0013)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .pc_write_enable    (pc_write_enable),
        .if_id_write_enable (if_id_write_enable),
        .flush_ex           (flush_ex),
        .pc_redirect        (pc_redirect),
        .redirect_target    (redirect_target),
        .if_instr           (if_instr),
        .id_rs1             (id_rs1),
        .id_rs2             (id_rs2),
        .id_rd              (id_rd),
        .id_rs1_data        (id_rs1_data),
        .id_rs2_data        (id_rs2_data),
        .id_imm             (id_imm),
        .id_alu_ctrl        (id_alu_ctrl),
        .id_regwrite        (id_regwrite),
        .id_memread         (id_memread),
        .id_memwrite        (id_memwrite),
        .id_branch          (id_branch),
        .id_jump            (id_jump),
        .pc                 (pc),
        .id_pc              (id_pc),
        .id_instr           (id_instr),
        .id_valid           (id_valid),
        .ex_pc              (ex_pc),
        .ex_rs1_data        (ex_rs1_data),
        .ex_rs2_data        (ex_rs2_data),
        .ex_imm             (ex_imm),
        .ex_rs1             (ex_rs1),
        .ex_rs2             (ex_rs2),
        .ex_rd              (ex_rd),
        .ex_alu_ctrl        (ex_alu_ctrl),
        .ex_regwrite        (ex_regwrite),
        .ex_memread         (ex_memread),
        .ex_memwrite        (ex_memwrite),
        .ex_branch          (ex_branch),
        .ex_jump            (ex_jump),
        .ex_valid           (ex_valid),
        .stall_cycles       (stall_cycles),
        .flush_cycles       (flush_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge, then settle before sampling/driving.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle_ctrl();
        pc_write_enable    = 1'b1;
        if_id_write_enable = 1'b1;
        flush_ex           = 1'b0;
        pc_redirect        = 1'b0;
        redirect_target    = 32'h0;
    endtask

    initial begin
        // Fixed decode fields for the whole run.
        id_rs1 = 5'd1;  id_rs2 = 5'd2;  id_rd = 5'd3;
        id_rs1_data = 32'h0000_0011; id_rs2_data = 32'h0000_0022; id_imm = 32'h0000_0033;
        id_alu_ctrl = 4'h5;
        id_regwrite = 1'b1; id_memread = 1'b1; id_memwrite = 1'b0; id_branch = 1'b0; id_jump = 1'b0;
        if_instr = 32'h00A0_0093;

        // Reset with conflicting controls active: reset must win.
        rst                = 1'b1;
        pc_write_enable    = 1'b0;
        if_id_write_enable = 1'b0;
        flush_ex           = 1'b1;
        pc_redirect        = 1'b1;
        redirect_target    = 32'h0000_0500;
        tick();
        chk("rst_pc",       pc,           32'h0);
        chk("rst_id_pc",    id_pc,        32'h0);
        chk("rst_id_instr", id_instr,     32'h0000_0013);
        chk("rst_id_valid", id_valid,     1'b0);
        chk("rst_ex_valid", ex_valid,     1'b0);
        chk("rst_ex_rd",    ex_rd,        5'd0);
        chk("rst_stall",    stall_cycles, 32'd0);
        chk("rst_flush",    flush_cycles, 32'd0);

        // Free run.
        rst = 1'b0;
        idle_ctrl();
        tick(); // edge 1
        chk("run1_pc",       pc,          32'h4);
        chk("run1_id_pc",    id_pc,       32'h0);
        chk("run1_id_instr", id_instr,    32'h00A0_0093);
        chk("run1_id_valid", id_valid,    1'b1);
        chk("run1_ex_valid", ex_valid,    1'b0);
        chk("run1_ex_regwr", ex_regwrite, 1'b0);
        tick(); // edge 2
        chk("run2_pc",       pc,          32'h8);
        chk("run2_ex_valid", ex_valid,    1'b1);
        chk("run2_ex_pc",    ex_pc,       32'h0);
        chk("run2_ex_rd",    ex_rd,       5'd3);
        chk("run2_ex_rs1",   ex_rs1,      5'd1);
        chk("run2_ex_rs2d",  ex_rs2_data, 32'h22);
        chk("run2_ex_imm",   ex_imm,      32'h33);
        chk("run2_ex_alu",   ex_alu_ctrl, 4'h5);
        chk("run2_ex_regwr", ex_regwrite, 1'b1);
        chk("run2_ex_memrd", ex_memread,  1'b1);
        tick(); // edge 3
        tick(); // edge 4
        chk("run4_pc",       pc,          32'h10);
        chk("run4_id_pc",    id_pc,       32'hC);

        // Load-use stall for one cycle at pc=0x10.
        pc_write_enable    = 1'b0;
        if_id_write_enable = 1'b0;
        tick(); // edge 5
        chk("lu_pc",        pc,           32'h10);
        chk("lu_id_pc",     id_pc,        32'hC);
        chk("lu_id_valid",  id_valid,     1'b1);
        chk("lu_ex_valid",  ex_valid,     1'b0);
        chk("lu_ex_memrd",  ex_memread,   1'b0);
        chk("lu_ex_rd",     ex_rd,        5'd0);
        chk("lu_stall",     stall_cycles, 32'd1);
        chk("lu_flush",     flush_cycles, 32'd0);
        idle_ctrl();
        tick(); // edge 6
        chk("lu_rel_pc",    pc,           32'h14);
        chk("lu_rel_id_pc", id_pc,        32'h10);
        chk("lu_rel_ex_pc", ex_pc,        32'hC);
        chk("lu_rel_exv",   ex_valid,     1'b1);

        // Redirect with flush.
        pc_redirect     = 1'b1;
        redirect_target = 32'h0000_0100;
        flush_ex        = 1'b1;
        tick(); // edge 7
        chk("rd_pc",       pc,           32'h100);
        chk("rd_id_instr", id_instr,     32'h0000_0013);
        chk("rd_id_valid", id_valid,     1'b0);
        chk("rd_id_pc",    id_pc,        32'h14);
        chk("rd_ex_regwr", ex_regwrite,  1'b0);
        chk("rd_ex_valid", ex_valid,     1'b0);
        chk("rd_flush",    flush_cycles, 32'd1);
        idle_ctrl();
        tick(); // edge 8: squashed slot reaches EX as invalid
        chk("rd2_pc",      pc,           32'h104);
        chk("rd2_id_pc",   id_pc,        32'h100);
        chk("rd2_ex_valid", ex_valid,    1'b0);
        chk("rd2_ex_regwr", ex_regwrite, 1'b0);
        chk("rd2_ex_pc",   ex_pc,        32'h14);
        tick(); // edge 9
        chk("rd3_ex_pc",   ex_pc,        32'h100);
        chk("rd3_ex_valid", ex_valid,    1'b1);

        // Stall and redirect in the same cycle: hold wins.
        pc_write_enable    = 1'b0;
        if_id_write_enable = 1'b0;
        pc_redirect        = 1'b1;
        redirect_target    = 32'h0000_0200;
        tick(); // edge 10
        chk("sr_pc",       pc,           32'h108);
        chk("sr_id_pc",    id_pc,        32'h104);
        chk("sr_id_instr", id_instr,     32'h00A0_0093);
        chk("sr_id_valid", id_valid,     1'b1);
        chk("sr_ex_valid", ex_valid,     1'b0);
        chk("sr_ex_pc",    ex_pc,        32'h0);
        chk("sr_stall",    stall_cycles, 32'd2);
        idle_ctrl();
        tick(); // edge 11
        chk("sr_rel_pc",   pc,           32'h10C);

        // All three hazards at once.
        pc_write_enable    = 1'b0;
        if_id_write_enable = 1'b0;
        flush_ex           = 1'b1;
        tick(); // edge 12
        chk("all_pc",      pc,           32'h10C);
        chk("all_id_pc",   id_pc,        32'h108);
        chk("all_ex_valid", ex_valid,    1'b0);
        chk("all_stall",   stall_cycles, 32'd3);
        chk("all_flush",   flush_cycles, 32'd2);
        idle_ctrl();
        tick(); // edge 13
        chk("all_rel_pc",  pc,           32'h110);

        // PC wrap at the top of the address space.
        pc_redirect     = 1'b1;
        redirect_target = 32'hFFFF_FFFC;
        tick(); // edge 14
        chk("wrap_top",    pc,           32'hFFFF_FFFC);
        idle_ctrl();
        tick(); // edge 15
        chk("wrap_zero",   pc,           32'h0);
        chk("wrap_id_pc",  id_pc,        32'hFFFF_FFFC);
        chk("wrap_id_v",   id_valid,     1'b1);

        // Different fetched word flows into IF/ID.
        if_instr = 32'hDEAD_BEEF;
        tick(); // edge 16
        chk("ins_pc",      pc,           32'h4);
        chk("ins_id_pc",   id_pc,        32'h0);
        chk("ins_id_inst", id_instr,     32'hDEAD_BEEF);
        if_instr = 32'h00A0_0093;

        // Build stall_cycles up to 5, then reset mid-stall with a redirect pending.
        pc_write_enable    = 1'b0;
        if_id_write_enable = 1'b0;
        tick(); // edge 17
        tick(); // edge 18
        chk("pre_rst_stall", stall_cycles, 32'd5);
        chk("pre_rst_pc",    pc,           32'h4);
        pc_redirect     = 1'b1;
        redirect_target = 32'h0000_0800;
        rst = 1'b1;
        tick(); // edge 19
        chk("mrst_pc",     pc,           32'h0);
        chk("mrst_stall",  stall_cycles, 32'd0);
        chk("mrst_flush",  flush_cycles, 32'd0);
        chk("mrst_ex_v",   ex_valid,     1'b0);
        chk("mrst_id_v",   id_valid,     1'b0);
        chk("mrst_id_ins", id_instr,     32'h0000_0013);
        rst = 1'b0;
        idle_ctrl();
        tick(); // edge 20
        chk("post_rst_pc",    pc,    32'h4);
        chk("post_rst_id_pc", id_pc, 32'h0);
        chk("post_rst_id_v",  id_valid, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
